// File: rtl/dev_timer_mc.sv
// Multi-channel down-counter timer behind an 8-bit bus window.
// All channels share one prescaler. Pending flags are sticky, write-1-to-clear, and OR-ed into dev_irq.
module dev_timer_mc #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int PSC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        dev_irq,
    output logic [31:0] dev_out,
    input  logic [31:0] dev_in,
    input  logic [7:0]  dev_addr,
    input  logic        we
);

    localparam logic [1:0]       MODE_ONESHOT = 2'b00;
    localparam logic [1:0]       MODE_RELOAD  = 2'b01;
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  im;
    logic [N_CH-1:0]  pending;
    logic [1:0]       mode   [N_CH];
    logic [WIDTH-1:0] preset [N_CH];
    logic [WIDTH-1:0] count  [N_CH];
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_cnt;

    logic             tick;
    logic             word_ok;
    logic             chan_win;
    logic             wr_status;
    logic             wr_psc;
    logic [N_CH-1:0]  wr_ctrl;
    logic [N_CH-1:0]  wr_pre;
    logic [N_CH-1:0]  hw_set;
    logic [N_CH-1:0]  clr;

    function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] zext_p(input logic [PSC_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[PSC_W-1:0] = v;
        return r;
    endfunction

    assign tick      = (psc_cnt == psc);
    assign word_ok   = (dev_addr[1:0] == 2'b00);
    assign chan_win  = word_ok & ~dev_addr[7];
    assign wr_status = we & (dev_addr == 8'h80);
    assign wr_psc    = we & (dev_addr == 8'h84);
    assign clr       = wr_status ? dev_in[N_CH-1:0] : '0;

    // A CPU write to a channel suppresses that channel's tick update, including the pending set.
    always_comb begin
        wr_ctrl = '0;
        wr_pre  = '0;
        hw_set  = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_ctrl[i] = we & chan_win & (dev_addr[6:4] == 3'(i)) & (dev_addr[3:2] == 2'd0);
            wr_pre[i]  = we & chan_win & (dev_addr[6:4] == 3'(i)) & (dev_addr[3:2] == 2'd1);
            hw_set[i]  = tick & en[i] & ~wr_ctrl[i] & ~wr_pre[i] & (count[i] == ONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc     <= '0;
            psc_cnt <= '0;
        end else if (wr_psc) begin
            psc     <= dev_in[PSC_W-1:0];
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en <= '0;
            im <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mode[i]   <= '0;
                preset[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_ctrl[i]) begin
                    en[i]   <= dev_in[0];
                    mode[i] <= dev_in[2:1];
                    im[i]   <= dev_in[3];
                end else if (wr_pre[i]) begin
                    preset[i] <= dev_in[WIDTH-1:0];
                    count[i]  <= dev_in[WIDTH-1:0];
                end else if (tick && en[i]) begin
                    if (count[i] > ONE) begin
                        count[i] <= count[i] - ONE;
                    end else if (count[i] == ONE) begin
                        count[i] <= '0;
                        if (mode[i] == MODE_ONESHOT) en[i] <= 1'b0;
                    end else if (mode[i] == MODE_RELOAD) begin
                        count[i] <= preset[i];
                    end else if (mode[i] == MODE_ONESHOT) begin
                        en[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= (pending & ~clr) | hw_set;
    end

    assign dev_irq = |(pending & im);

    always_comb begin
        dev_out = '0;
        if (chan_win) begin
            for (int i = 0; i < N_CH; i++) begin
                if (dev_addr[6:4] == 3'(i)) begin
                    case (dev_addr[3:2])
                        2'd0:    dev_out = {28'b0, im[i], mode[i], en[i]};
                        2'd1:    dev_out = zext_w(preset[i]);
                        2'd2:    dev_out = zext_w(count[i]);
                        default: dev_out = '0;
                    endcase
                end
            end
        end else if (dev_addr == 8'h80) begin
            for (int b = 0; b < N_CH; b++) dev_out[b] = pending[b];
        end else if (dev_addr == 8'h84) begin
            dev_out = zext_p(psc);
        end
    end

    logic unused_in;
    assign unused_in = ^dev_in;

endmodule

// File: tb/tb_dev_timer_mc.sv
// Bench for dev_timer_mc: directed scenarios plus random bus traffic checked against
// a register-level model of the timer kept in plain integers.
module tb_dev_timer_mc;

    localparam int N = 3;
    localparam int W = 12;
    localparam int P = 6;
    localparam int unsigned WMASK = (1 << W) - 1;
    localparam int unsigned PMASK = (1 << P) - 1;
    localparam int unsigned NMASK = (1 << N) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic [7:0]  dev_addr = '0;
    logic [31:0] dev_in = '0;
    logic [31:0] dev_out;
    logic        dev_irq;

    always #5 clk = ~clk;

    dev_timer_mc #(.N_CH(N), .WIDTH(W), .PSC_W(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .dev_irq  (dev_irq),
        .dev_out  (dev_out),
        .dev_in   (dev_in),
        .dev_addr (dev_addr),
        .we       (we)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register-level model: ctrl holds {im, mode, en} as a 4-bit number.
    int unsigned m_ctrl [N];
    int unsigned m_pre  [N];
    int unsigned m_cnt  [N];
    int unsigned m_pend, m_psc, m_pcnt;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_ctrl[i] = 0;
            m_pre[i]  = 0;
            m_cnt[i]  = 0;
        end
        m_pend = 0;
        m_psc  = 0;
        m_pcnt = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int unsigned ch, off;
        if (a[1:0] != 2'b00) return 0;
        if (a == 8'h80) return m_pend;
        if (a == 8'h84) return m_psc;
        if (a >= 8'h80) return 0;
        ch  = a / 16;
        off = a % 16;
        if (ch >= N) return 0;
        case (off)
            0:       return m_ctrl[ch];
            4:       return m_pre[ch];
            8:       return m_cnt[ch];
            default: return 0;
        endcase
    endfunction

    function automatic logic model_irq();
        for (int i = 0; i < N; i++)
            if (((m_pend >> i) & 1) != 0 && ((m_ctrl[i] >> 3) & 1) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic [7:0] a, input logic [31:0] d);
        bit tick;
        int unsigned set, base, md;
        tick = (m_pcnt == m_psc);
        set  = 0;
        for (int ch = 0; ch < N; ch++) begin
            base = ch * 16;
            md   = (m_ctrl[ch] >> 1) & 3;
            if (w && a == base) begin
                m_ctrl[ch] = d & 32'hF;
            end else if (w && a == base + 4) begin
                m_pre[ch] = d & WMASK;
                m_cnt[ch] = m_pre[ch];
            end else if (tick && (m_ctrl[ch] & 1) != 0) begin
                if (m_cnt[ch] > 1) begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                end else if (m_cnt[ch] == 1) begin
                    m_cnt[ch] = 0;
                    set |= (1 << ch);
                    if (md == 0) m_ctrl[ch] &= ~32'd1;
                end else if (md == 1) begin
                    m_cnt[ch] = m_pre[ch];
                end else if (md == 0) begin
                    m_ctrl[ch] &= ~32'd1;
                end
            end
        end
        if (w && a == 8'h80) m_pend &= ~d;
        m_pend = (m_pend | set) & NMASK;
        if (w && a == 8'h84) begin
            m_psc  = d & PMASK;
            m_pcnt = 0;
        end else if (tick) begin
            m_pcnt = 0;
        end else begin
            m_pcnt = m_pcnt + 1;
        end
    endfunction

    // One bus cycle, entered and left at a falling edge.
    task automatic cyc(input logic w, input logic [7:0] a, input logic [31:0] d);
        we = w;
        dev_addr = a;
        dev_in = d;
        #1;
        chk("read", dev_out, model_read(a));
        chk("irq", {31'b0, dev_irq}, {31'b0, model_irq()});
        @(posedge clk);
        model_step(w, a, d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] e);
        we = 1'b0;
        dev_addr = a;
        dev_in = '0;
        #1;
        chk(tag, dev_out, e);
        cyc(1'b0, a, 32'h0);
    endtask

    task automatic irq_exp(input string tag, input logic e);
        #1;
        chk(tag, {31'b0, dev_irq}, {31'b0, e});
    endtask

    function automatic logic [7:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
        if (r == 6) return 8'h80;
        if (r == 7) return 8'h84;
        if (r == 8) return 8'($urandom);
        return 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
    endfunction

    int exp_ch1 [11] = '{2, 1, 1, 1, 0, 0, 0, 2, 2, 2, 1};

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rd_exp("rst_ctrl", 8'h00, 0);
        rd_exp("rst_preset", 8'h04, 0);
        rd_exp("rst_count", 8'h08, 0);
        rd_exp("rst_status", 8'h80, 0);
        rd_exp("rst_psc", 8'h84, 0);
        irq_exp("rst_irq", 1'b0);

        // One-shot on ch0, prescaler bypassed.
        cyc(1'b1, 8'h84, 0);
        cyc(1'b1, 8'h04, 3);
        cyc(1'b1, 8'h00, 32'h9);
        rd_exp("oneshot_cnt3", 8'h08, 3);
        rd_exp("oneshot_cnt2", 8'h08, 2);
        rd_exp("oneshot_cnt1", 8'h08, 1);
        irq_exp("oneshot_irq", 1'b1);
        rd_exp("oneshot_cnt0", 8'h08, 0);
        rd_exp("oneshot_pend", 8'h80, 1);
        rd_exp("oneshot_ctrl", 8'h00, 8);
        cyc(1'b1, 8'h80, 1);
        irq_exp("w1c_irq", 1'b0);
        rd_exp("oneshot_hold", 8'h08, 0);

        // Auto-reload on ch1 with PSC=2.
        cyc(1'b1, 8'h84, 2);
        cyc(1'b1, 8'h14, 2);
        cyc(1'b1, 8'h10, 32'hB);
        foreach (exp_ch1[k]) rd_exp("reload_cnt", 8'h18, exp_ch1[k]);
        cyc(1'b1, 8'h10, 0);
        cyc(1'b1, 8'h80, 7);

        for (int n = 0; n < 3000; n++) begin
            a = rand_addr();
            if ($urandom_range(0, 9) < 3) begin
                if (a[3:0] == 4'h4 && a < 8'h80)
                    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                else if (a == 8'h84)
                    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
                else
                    d = $urandom;
                cyc(1'b1, a, d);
            end else begin
                cyc(1'b0, a, 32'h0);
            end
        end

        for (int ch = 0; ch < N; ch++) cyc(1'b1, 8'(ch * 16), 0);
        cyc(1'b1, 8'h80, 7);
        cyc(1'b1, 8'h84, 0);

        // Masked expiry, then unmask without a new expiry.
        cyc(1'b1, 8'h24, 1);
        cyc(1'b1, 8'h20, 32'h3);
        rd_exp("mask_cnt", 8'h28, 1);
        irq_exp("mask_irq", 1'b0);
        rd_exp("mask_pend", 8'h80, 4);
        cyc(1'b1, 8'h20, 32'hB);
        irq_exp("unmask_irq", 1'b1);
        cyc(1'b1, 8'h20, 0);
        cyc(1'b1, 8'h80, 7);

        // W1C on the same edge as the hardware set.
        cyc(1'b1, 8'h04, 2);
        cyc(1'b1, 8'h00, 32'h1);
        cyc(1'b0, 8'h08, 0);
        cyc(1'b1, 8'h80, 1);
        rd_exp("w1c_vs_set", 8'h80, 1);

        // PRESET write on a tick cycle.
        cyc(1'b1, 8'h80, 1);
        cyc(1'b1, 8'h04, 10);
        cyc(1'b1, 8'h00, 32'h1);
        cyc(1'b0, 8'h08, 0);
        cyc(1'b1, 8'h04, 7);
        rd_exp("preset_beats_tick", 8'h08, 7);

        // Width truncation and unmapped addresses.
        cyc(1'b1, 8'h14, 32'h1FFF);
        rd_exp("preset_trunc", 8'h14, 32'hFFF);
        cyc(1'b1, 8'h30, 32'hF);
        rd_exp("oob_ctrl", 8'h30, 0);
        rd_exp("oob_count", 8'h38, 0);
        rd_exp("unaligned", 8'h06, 0);
        rd_exp("reserved", 8'h0C, 0);

        // Reset in the middle of a count.
        cyc(1'b1, 8'h84, 1);
        cyc(1'b1, 8'h04, 32'h50);
        cyc(1'b1, 8'h00, 32'h9);
        repeat (4) cyc(1'b0, 8'h08, 0);
        rst = 1'b0;
        dev_addr = 8'h08;
        #1 chk("midrst_count", dev_out, 0);
        chk("midrst_irq", {31'b0, dev_irq}, 0);
        dev_addr = 8'h00;
        #1 chk("midrst_ctrl", dev_out, 0);
        dev_addr = 8'h80;
        #1 chk("midrst_status", dev_out, 0);
        dev_addr = 8'h84;
        #1 chk("midrst_psc", dev_out, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 20; n++) cyc(1'b0, rand_addr(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dev_timer_mc.md
Name: dev_timer_mc

Overview:
Parametrised multi-channel successor to the single-channel bus timer. It provides N_CH independent down-counters behind one 8-bit device address window and shares one programmable prescaler across all channels. Each channel has sticky interrupt-pending flags with write-1-to-clear and a single OR-ed interrupt line to the CP0/bridge. It attaches to the system bridge exactly like the existing devices: one cycle write, combinational read.

Parameters:
N_CH, 4, number of timer channels (1..8)
WIDTH, 32, counter/preset width in bits (1..32)
PSC_W, 16, prescaler register width in bits (1..32)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
dev_irq  output  1  OR over channels of (pending[i] & im[i])
dev_out  output  32  read data for dev_addr, combinational
dev_in  input  32  write data
dev_addr  input  8  byte address within device window
we  input  1  write strobe, one write per asserted cycle

Behaviour:
- Address map, channel i at base 16*i, i < N_CH:
  - +0x0 CTRL (RW): [0] en, [2:1] mode, [3] im; reads {28'b0, im, mode, en}.
  - +0x4 PRESET (RW): reads zero-extended.
  - +0x8 COUNT (RO): reads zero-extended.
  - +0xC reserved: reads 0.
- Global registers:
  - 0x80 STATUS: [N_CH-1:0] pending. Writing 1 to a bit clears it; writing 0 leaves it.
  - 0x84 PSC (RW): zero-extended.
- All other addresses (including channels >= N_CH) read 0; writes to them are ignored.
- Reset (rst low, async): every CTRL, PRESET, COUNT, pending, PSC and psc_cnt goes to 0. dev_irq=0.
- Prescaler: psc_cnt counts 0..PSC; tick=1 in the cycle psc_cnt==PSC, then psc_cnt wraps to 0. PSC=0 gives a tick every cycle. A write to PSC loads PSC and clears psc_cnt in the same edge.
- Write PRESET: preset<=dev_in[WIDTH-1:0], count<=same. The channel's pending bit is unchanged.
- Write CTRL: fields <= dev_in[3:0]. The count is unchanged.
- Per channel, on a tick with en=1 and no write to that channel this cycle:
  - count>1: count-1.
  - count==1: count<=0 and pending<=1. In mode 00, en is also cleared on this same edge (one-shot stop).
  - count==0: in mode 01, count<=preset (reload, no new pending). In mode 00, en<=0. Modes 10/11 are reserved: hold count, no pending.
  - Mode 01 therefore gives a period of preset+1 ticks after the first expiry. With preset==0 it stays at 0 and never raises pending.
- en=0 or no tick: count holds.
- Simultaneous events:
  - A CPU write to CTRL/PRESET of a channel beats that channel's tick update in the same cycle.
  - A STATUS W1C and a hardware set on the same bit in the same cycle: the set wins (pending=1).
  - A PSC write in the same cycle as a tick: the tick still applies to channels this cycle.
- dev_irq is combinational from registered pending/im. Clearing im masks the interrupt but keeps pending.
- Reset asserted mid-count aborts immediately. No partial state survives.
- COUNT reads reflect the value after the last clock edge (no bypass of same-cycle writes).

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0x80, 0x84 → all 0; dev_irq=0.
- PSC=0; ch0 PRESET=3, CTRL=0x9 (im=1, mode 00, en=1):
  - COUNT reads 2,1,0 on successive cycles.
  - pending[0]=1 and dev_irq=1 on the edge count reaches 0; CTRL reads 0x8.
  - count stays 0; write STATUS=0x1 → dev_irq=0.
- PSC=2; ch1 PRESET=2, CTRL=0xB (auto-reload):
  - count decrements every 3 clks: 2→1→0→2→1→0.
  - pending[1] set at each 1→0 step; first assertion 6 clks after enable.
- ch2 PRESET=1, CTRL=0x3 (im=0):
  - after the tick, pending[2]=1, dev_irq=0.
  - write CTRL=0xB → dev_irq=1 without a new expiry.
- Collision cases:
  - W1C to STATUS bit 0 on the same cycle ch0 goes 1→0 → pending[0] remains 1.
  - PRESET write to ch0 on a tick cycle → COUNT reads the written value, not value-1.
- N_CH=2, WIDTH=8: write PRESET=0x1FF → reads 0xFF; reads at 0x20 and 0x28 → 0; STATUS bits [31:2]=0.
- Mid-count: ch0 counting at 0x50; pull rst low → COUNT, CTRL, STATUS read 0 immediately and dev_irq=0.
